setpoint_slew: RTL and testbench

SETPOINT_SLEW -- requirements
Module: setpoint_slew

---
 rtl/setpoint_slew.sv | 168 ++++++++++++++++
 tb/tb_setpoint_slew.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/setpoint_slew.sv
//==============================================================================
// Module   : setpoint_slew
// Brief    : Slew-rate limiter between the command decoder and the flight
//            controller. It moves the attitude and thrust setpoints toward
//            their targets by at most one step per update tick.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module setpoint_slew #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter logic [15:0] ANG_STEP   = 16'd8,
    parameter logic [8:0]  THRST_STEP = 9'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_ptch,
    input  logic [15:0] d_roll,
    input  logic [15:0] d_yaw,
    input  logic [8:0]  thrst,
    input  logic        motors_off,
    input  logic        inertial_cal,
    output logic [15:0] s_ptch,
    output logic [15:0] s_roll,
    output logic [15:0] s_yaw,
    output logic [8:0]  s_thrst,
    output logic        settled,
    output logic        tick
);

    localparam int unsigned        CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_SLEW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [15:0]      ptch_q,  ptch_d;
    logic [15:0]      roll_q,  roll_d;
    logic [15:0]      yaw_q,   yaw_d;
    logic [8:0]       thrst_q, thrst_d;

    // Differences are taken one bit wider than the operands so that a full
    // -32768 -> +32767 swing never wraps; the result cannot overshoot the
    // target, so truncating back to 16 bits is always exact.
    function automatic logic [15:0] slew_ang(input logic [15:0] tgt,
                                             input logic [15:0] cur);
        logic signed [16:0] diff;
        logic signed [16:0] step;
        diff = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
        step = $signed({1'b0, ANG_STEP});
        if (diff > step) begin
            slew_ang = cur + ANG_STEP;
        end else if (diff < -step) begin
            slew_ang = cur - ANG_STEP;
        end else begin
            slew_ang = tgt;
        end
    endfunction

    function automatic logic [8:0] slew_thr(input logic [8:0] tgt,
                                            input logic [8:0] cur);
        logic signed [9:0] diff;
        logic signed [9:0] step;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = $signed({1'b0, THRST_STEP});
        if (diff > step) begin
            slew_thr = cur + THRST_STEP;
        end else if (diff < -step) begin
            slew_thr = cur - THRST_STEP;
        end else begin
            slew_thr = tgt;
        end
    endfunction

    assign tick    = (state_q == ST_SLEW) && (cnt_q == CNT_MAX);
    assign settled = (state_q == ST_SLEW) &&
                     (ptch_q == d_ptch) && (roll_q == d_roll) &&
                     (yaw_q == d_yaw) && (thrst_q == thrst);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        thrst_d = thrst_q;

        // Shutdown wins over everything except reset and drops outputs at once.
        if (motors_off) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    cnt_d   = '0;
                    ptch_d  = '0;
                    roll_d  = '0;
                    yaw_d   = '0;
                    thrst_d = '0;
                    state_d = inertial_cal ? ST_HOLD : ST_SLEW;
                end
                ST_HOLD: begin
                    if (!inertial_cal) begin
                        state_d = ST_SLEW;
                    end
                end
                ST_SLEW: begin
                    if (tick) begin
                        cnt_d   = '0;
                        ptch_d  = slew_ang(d_ptch, ptch_q);
                        roll_d  = slew_ang(d_roll, roll_q);
                        yaw_d   = slew_ang(d_yaw, yaw_q);
                        thrst_d = slew_thr(thrst, thrst_q);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (inertial_cal) begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    ptch_d  = '0;
                    roll_d  = '0;
                    yaw_d   = '0;
                    thrst_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
        end
    end

    assign s_ptch  = ptch_q;
    assign s_roll  = roll_q;
    assign s_yaw   = yaw_q;
    assign s_thrst = thrst_q;

endmodule

`default_nettype wire

// File: tb/tb_setpoint_slew.sv
//==============================================================================
// Module   : tb_setpoint_slew
// Brief    : Scoreboard bench for setpoint_slew: directed scenarios followed
//            by random stimulus, compared against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_setpoint_slew;

    localparam int TD = 4;
    localparam int AS = 8;
    localparam int TS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_ptch = '0, d_roll = '0, d_yaw = '0;
    logic [8:0]  thrst = '0;
    logic        motors_off = 1'b0, inertial_cal = 1'b0;
    logic [15:0] s_ptch, s_roll, s_yaw;
    logic [8:0]  s_thrst;
    logic        settled, tick;

    setpoint_slew #(
        .TICK_DIV   (TD),
        .ANG_STEP   (16'(AS)),
        .THRST_STEP (9'(TS))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .motors_off   (motors_off),
        .inertial_cal (inertial_cal),
        .s_ptch       (s_ptch),
        .s_roll       (s_roll),
        .s_yaw        (s_yaw),
        .s_thrst      (s_thrst),
        .settled      (settled),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int tk;
        int st;
        int p, r, y, t;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc_no  = 0;

    // Behavioural model: mode, position in the update period, output values.
    typedef enum {M_OFF, M_HOLD, M_SLEW} mode_t;
    mode_t m_mode = M_OFF;
    int    m_phase = 0;
    int    m_p = 0, m_r = 0, m_y = 0, m_t = 0;

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int approach(input int tgt, input int cur, input int step);
        if (tgt - cur > step) return cur + step;
        if (cur - tgt > step) return cur - step;
        return tgt;
    endfunction

    function automatic int m_tick();
        return (m_mode == M_SLEW && m_phase == TD - 1) ? 1 : 0;
    endfunction

    function automatic int m_settled();
        return (m_mode == M_SLEW && m_p == sx(d_ptch) && m_r == sx(d_roll) &&
                m_y == sx(d_yaw) && m_t == int'(thrst)) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int tk;
        tk = m_tick();
        if (rst || motors_off) begin
            m_mode = M_OFF; m_phase = 0;
            m_p = 0; m_r = 0; m_y = 0; m_t = 0;
        end else begin
            case (m_mode)
                M_OFF:  m_mode = inertial_cal ? M_HOLD : M_SLEW;
                M_HOLD: if (!inertial_cal) m_mode = M_SLEW;
                default: begin
                    if (tk == 1) begin
                        m_p = approach(sx(d_ptch), m_p, AS);
                        m_r = approach(sx(d_roll), m_r, AS);
                        m_y = approach(sx(d_yaw), m_y, AS);
                        m_t = approach(int'(thrst), m_t, TS);
                    end
                    m_phase = (m_phase + 1) % TD;
                    if (inertial_cal) m_mode = M_HOLD;
                end
            endcase
        end
    endtask

    // One clock: record what the DUT must show now, then step the model.
    task automatic cyc(input int n);
        exp_t e;
        repeat (n) begin
            e.cyc = cyc_no;
            e.tk  = m_tick();
            e.st  = m_settled();
            e.p   = m_p; e.r = m_r; e.y = m_y; e.t = m_t;
            sb.push_back(e);
            model_edge();
            cyc_no++;
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tick",    e.cyc, int'(tick),    e.tk);
                chk("settled", e.cyc, int'(settled), e.st);
                chk("s_ptch",  e.cyc, sx(s_ptch),    e.p);
                chk("s_roll",  e.cyc, sx(s_roll),    e.r);
                chk("s_yaw",   e.cyc, sx(s_yaw),     e.y);
                chk("s_thrst", e.cyc, int'(s_thrst), e.t);
            end
        end
    end

    function automatic logic [15:0] pick_ang(input int cur);
        logic [15:0] v;
        case ($urandom_range(0, 4))
            0:       v = 16'h7FFF;
            1:       v = 16'h8000;
            2:       v = 16'($urandom_range(0, 65535));
            default: v = 16'(cur + int'($urandom_range(0, 64)) - 32);
        endcase
        return v;
    endfunction

    initial begin : driver
        int guard;
        model_edge();
        @(negedge clk);
        cyc(2);

        // Ramp pitch 0 -> 0x14 in steps of 8.
        rst = 1'b0; d_ptch = 16'h0014;
        cyc(20);

        // Negative roll ramp and a full-scale yaw swing from 0x8000 to 0x7FFF.
        d_roll = 16'hFFEC; d_yaw = 16'h8000;
        guard = 0;
        while (m_y != -32768 && guard < 20000) begin
            cyc(1);
            guard++;
        end
        d_yaw = 16'h7FFF;
        cyc(10);

        // Thrust up to 5 and back down to 0.
        thrst = 9'd5;
        cyc(16);
        thrst = 9'd0;
        cyc(16);

        // Calibration freeze mid-ramp.
        thrst = 9'd200; d_ptch = 16'h0100;
        cyc(10);
        inertial_cal = 1'b1;
        cyc(20);
        inertial_cal = 1'b0;
        cyc(12);

        // Shutdown with thrust at 100, then ramp again from 0.
        guard = 0;
        while (m_t != 100 && guard < 2000) begin
            cyc(1);
            guard++;
        end
        motors_off = 1'b1;
        cyc(1);
        motors_off = 1'b0;
        cyc(14);

        // One-clock reset during calibration.
        inertial_cal = 1'b1; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(6);
        inertial_cal = 1'b0;
        cyc(12);

        // Random phase: targets, calibration, shutdown and reset events.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) d_ptch = pick_ang(m_p);
            if ($urandom_range(0, 7) == 0) d_roll = pick_ang(m_r);
            if ($urandom_range(0, 7) == 0) d_yaw  = pick_ang(m_y);
            if ($urandom_range(0, 7) == 0) thrst  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0) inertial_cal = ~inertial_cal;
            motors_off = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        rst = 1'b0; motors_off = 1'b0; inertial_cal = 1'b0;
        cyc(4);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
